s2mm_sts_gen: RTL and testbench

S2MM_STS_GEN -- requirements
Module: s2mm_sts_gen

---
 rtl/s2mm_sts_gen_pkg.sv | 29 ++
 rtl/s2mm_len_fifo.sv | 63 ++++++
 rtl/s2mm_sts_gen.sv | 185 ++++++++++++++++++
 tb/tb_s2mm_sts_gen.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/s2mm_sts_gen_pkg.sv
// Shared types and constants for the S2MM status generator and its length queue.
// Holds the status FSM encoding, the fixed status words and the queued length entry.
package s2mm_sts_gen_pkg;

    localparam int          STS_WORDS = 6;
    localparam int          LEN_W     = 23;
    localparam logic [31:0] STS_FLAG  = 32'h5000_0000;
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FLAG = 3'd1,
        ST_APP0 = 3'd2,
        ST_APP1 = 3'd3,
        ST_APP2 = 3'd4,
        ST_APP3 = 3'd5,
        ST_APP4 = 3'd6
    } sts_state_t;

    typedef struct packed {
        logic             sat;
        logic [LEN_W-1:0] len;
    } len_ent_t;

    function automatic logic [31:0] app4_word(input len_ent_t ent);
        return {ent.sat, 8'h00, ent.len};
    endfunction

endpackage

// File: rtl/s2mm_len_fifo.sv
// Completed-packet length queue: synchronous FWFT FIFO, head visible same cycle as non-empty.
// A push on a full queue is accepted only when a pop happens in the same cycle; otherwise ignored.
module s2mm_len_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_dat,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_dat,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign count   = cnt;
    assign pop_dat = mem[rd_ptr];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/s2mm_sts_gen.sv
// Counts bytes of each S2MM packet and emits a 6-word status packet per completed packet.
// First status word one cycle after a length is queued; words hold while sts_tready is low, s2mm_hold when queue full.
module s2mm_sts_gen
    import s2mm_sts_gen_pkg::*;
#(
    parameter int C_S_AXIS_S2MM_TDATA_WIDTH     = 128,
    parameter int C_S_AXIS_S2MM_STS_TDATA_WIDTH = 32,
    parameter int C_LEN_Q_DEPTH                 = 4
) (
    input  logic                                         m_axi_s2mm_aclk,
    input  logic                                         axi_resetn,
    input  logic                                         s_axis_s2mm_tvalid,
    input  logic                                         s_axis_s2mm_tready,
    input  logic                                         s_axis_s2mm_tlast,
    input  logic [C_S_AXIS_S2MM_TDATA_WIDTH/8-1:0]       s_axis_s2mm_tkeep,
    output logic                                         s2mm_hold,
    output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH-1:0]     s_axis_s2mm_sts_tdata,
    output logic [C_S_AXIS_S2MM_STS_TDATA_WIDTH/8-1:0]   s_axis_s2mm_sts_tkeep,
    output logic                                         s_axis_s2mm_sts_tvalid,
    output logic                                         s_axis_s2mm_sts_tlast,
    input  logic                                         s_axis_s2mm_sts_tready,
    output logic                                         sts_overflow
);

    localparam int KEEP_W = C_S_AXIS_S2MM_TDATA_WIDTH / 8;
    localparam int PC_W   = $clog2(KEEP_W + 1);
    localparam int QCW    = $clog2(C_LEN_Q_DEPTH) + 1;

    logic [PC_W-1:0]  pc;
    logic             beat;
    logic [LEN_W:0]   sum;
    logic [LEN_W-1:0] sum_len;
    logic             sat_nxt;
    logic [LEN_W-1:0] acc;
    logic             sat;

    logic             q_push;
    len_ent_t         q_push_dat;
    logic             q_pop;
    len_ent_t         q_head;
    logic             q_empty;
    logic             q_full;
    logic [QCW-1:0]   q_count;

    sts_state_t       state;
    sts_state_t       state_nxt;
    logic [31:0]      tdata_r;
    logic [31:0]      tdata_nxt;
    logic             tlast_r;
    logic             tlast_nxt;
    len_ent_t         len_r;

    always_comb begin
        pc = '0;
        for (int i = 0; i < KEEP_W; i++) begin
            pc = pc + PC_W'(s_axis_s2mm_tkeep[i]);
        end
    end

    assign beat    = s_axis_s2mm_tvalid & s_axis_s2mm_tready;
    assign sum     = {1'b0, acc} + (LEN_W + 1)'(pc);
    assign sum_len = sum[LEN_W] ? LEN_MAX : sum[LEN_W-1:0];
    assign sat_nxt = sat | sum[LEN_W];

    always_ff @(posedge m_axi_s2mm_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (beat) begin
            if (s_axis_s2mm_tlast) begin
                acc <= '0;
                sat <= 1'b0;
            end else begin
                acc <= sum_len;
                sat <= sat_nxt;
            end
        end
    end

    assign q_push     = beat & s_axis_s2mm_tlast;
    assign q_push_dat = '{sat: sat_nxt, len: sum_len};
    assign q_pop      = (state == ST_IDLE) & ~q_empty;
    assign s2mm_hold  = (q_count == QCW'(C_LEN_Q_DEPTH));

    s2mm_len_fifo #(
        .DEPTH (C_LEN_Q_DEPTH),
        .WIDTH ($bits(len_ent_t))
    ) u_len_fifo (
        .clk      (m_axi_s2mm_aclk),
        .rst_n    (axi_resetn),
        .push     (q_push),
        .push_dat (q_push_dat),
        .pop      (q_pop),
        .pop_dat  (q_head),
        .empty    (q_empty),
        .full     (q_full),
        .count    (q_count)
    );

    // A length finishing while the queue is full and nothing drains this cycle is lost.
    always_ff @(posedge m_axi_s2mm_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            sts_overflow <= 1'b0;
        end else if (q_push & q_full & ~q_pop) begin
            sts_overflow <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        tdata_nxt = tdata_r;
        tlast_nxt = tlast_r;
        case (state)
            ST_IDLE: begin
                if (!q_empty) begin
                    state_nxt = ST_FLAG;
                    tdata_nxt = STS_FLAG;
                    tlast_nxt = 1'b0;
                end
            end
            ST_FLAG: begin
                if (s_axis_s2mm_sts_tready) begin
                    state_nxt = ST_APP0;
                    tdata_nxt = '0;
                end
            end
            ST_APP0: begin
                if (s_axis_s2mm_sts_tready) begin
                    state_nxt = ST_APP1;
                end
            end
            ST_APP1: begin
                if (s_axis_s2mm_sts_tready) begin
                    state_nxt = ST_APP2;
                end
            end
            ST_APP2: begin
                if (s_axis_s2mm_sts_tready) begin
                    state_nxt = ST_APP3;
                end
            end
            ST_APP3: begin
                if (s_axis_s2mm_sts_tready) begin
                    state_nxt = ST_APP4;
                    tdata_nxt = app4_word(len_r);
                    tlast_nxt = 1'b1;
                end
            end
            ST_APP4: begin
                if (s_axis_s2mm_sts_tready) begin
                    state_nxt = ST_IDLE;
                    tdata_nxt = '0;
                    tlast_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                tdata_nxt = '0;
                tlast_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge m_axi_s2mm_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state   <= ST_IDLE;
            tdata_r <= '0;
            tlast_r <= 1'b0;
            len_r   <= '0;
        end else begin
            state   <= state_nxt;
            tdata_r <= tdata_nxt;
            tlast_r <= tlast_nxt;
            if (q_pop) begin
                len_r <= q_head;
            end
        end
    end

    assign s_axis_s2mm_sts_tvalid = (state != ST_IDLE);
    assign s_axis_s2mm_sts_tdata  = tdata_r;
    assign s_axis_s2mm_sts_tlast  = tlast_r;
    assign s_axis_s2mm_sts_tkeep  = '1;

endmodule

// File: tb/tb_s2mm_sts_gen.sv
// Bench for s2mm_sts_gen: table vectors, directed corner sequences and random packets vs a byte-count model.
// A wide data bus keeps the saturation packet short in cycles.
module tb_s2mm_sts_gen;
    import s2mm_sts_gen_pkg::*;

    localparam int DW    = 2048;
    localparam int KW    = DW / 8;
    localparam int DEPTH = 4;

    typedef struct {
        int          beats;
        logic [31:0] body;
        logic [31:0] lastk;
        logic [31:0] exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid = 1'b0;
    logic          s_tready = 1'b0;
    logic          s_tlast = 1'b0;
    logic [KW-1:0] s_tkeep = '0;
    logic          hold;
    logic [31:0]   sts_tdata;
    logic [3:0]    sts_tkeep;
    logic          sts_tvalid;
    logic          sts_tlast;
    logic          sts_tready = 1'b0;
    logic          ovf;

    int            mode = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    logic [31:0]   exp_q[$];
    int            widx = 0;
    bit            prev_stall = 0;
    logic [31:0]   prev_dat = '0;
    logic          prev_last = 1'b0;
    vec_t          tbl[7];

    always #5 clk = ~clk;

    s2mm_sts_gen #(
        .C_S_AXIS_S2MM_TDATA_WIDTH     (DW),
        .C_S_AXIS_S2MM_STS_TDATA_WIDTH (32),
        .C_LEN_Q_DEPTH                 (DEPTH)
    ) dut (
        .m_axi_s2mm_aclk        (clk),
        .axi_resetn             (rst_n),
        .s_axis_s2mm_tvalid     (s_tvalid),
        .s_axis_s2mm_tready     (s_tready),
        .s_axis_s2mm_tlast      (s_tlast),
        .s_axis_s2mm_tkeep      (s_tkeep),
        .s2mm_hold              (hold),
        .s_axis_s2mm_sts_tdata  (sts_tdata),
        .s_axis_s2mm_sts_tkeep  (sts_tkeep),
        .s_axis_s2mm_sts_tvalid (sts_tvalid),
        .s_axis_s2mm_sts_tlast  (sts_tlast),
        .s_axis_s2mm_sts_tready (sts_tready),
        .sts_overflow           (ovf)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [KW-1:0] ones(input int n);
        logic [KW-1:0] k = '0;
        for (int b = 0; b < n; b++) k[b] = 1'b1;
        return k;
    endfunction

    function automatic logic [KW-1:0] rand_keep();
        logic [KW-1:0] k = '0;
        case ($urandom_range(3))
            0: k = '1;
            1: k = '0;
            default: for (int w = 0; w < KW / 32; w++) k[w*32 +: 32] = $urandom;
        endcase
        return k;
    endfunction

    // Status length as the DMA should see it: byte total, clamped to 2^23-1 with bit 31 flagging the clamp.
    function automatic logic [31:0] model_word(input longint total);
        if (total >= 64'd8388608) return 32'h807F_FFFF;
        return 32'(total);
    endfunction

    // Sts_tready pattern generator: 0 always ready, 1 toggle, 2 random, other never ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       sts_tready = 1'b1;
                1:       sts_tready = !sts_tready;
                2:       sts_tready = 1'($urandom_range(1));
                default: sts_tready = 1'b0;
            endcase
        end
    end

    // Status monitor: words are sampled on the falling edge, ahead of the rising edge that accepts them.
    always @(negedge clk) begin
        if (!rst_n) begin
            widx = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(sts_tvalid), 32'd1);
                check("stall_data", sts_tdata, prev_dat);
                check("stall_last", 32'(sts_tlast), 32'(prev_last));
            end
            if (sts_tvalid && sts_tready) begin
                if (widx == 0) begin
                    check("flag_word", sts_tdata, STS_FLAG);
                end else if (widx < STS_WORDS - 1) begin
                    check("app_zero", sts_tdata, 32'h0);
                end else if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_status: got %08h expected no status", sts_tdata);
                end else begin
                    check("app4_len", sts_tdata, exp_q.pop_front());
                end
                check("tlast_pos", 32'(sts_tlast), 32'(widx == STS_WORDS - 1));
                widx = (widx == STS_WORDS - 1) ? 0 : widx + 1;
            end
            prev_stall = sts_tvalid && !sts_tready;
            prev_dat   = sts_tdata;
            prev_last  = sts_tlast;
        end
    end

    task automatic send_beat(input logic [KW-1:0] keep, input logic last, input int gap, input bit force_rdy);
        bit acc = 0;
        int guard = 0;
        s_tkeep = keep;
        s_tlast = last;
        while (!acc) begin
            s_tvalid = ($urandom_range(99) >= gap);
            s_tready = force_rdy ? 1'b1 : (($urandom_range(99) >= gap) && !hold);
            acc = s_tvalid && s_tready;
            tick();
            guard++;
            if (!acc && guard > 2000) begin
                n_checks++;
                n_fail++;
                $display("FAIL beat_timeout: got no acceptance expected a beat within 2000 cycles");
                break;
            end
        end
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic send_pkt(input int beats, input logic [KW-1:0] body, input logic [KW-1:0] lastk, input int gap);
        for (int b = 0; b < beats; b++) begin
            send_beat((b == beats - 1) ? lastk : body, b == beats - 1, gap, 1'b0);
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || widx != 0 || sts_tvalid) && k < budget) begin
            tick();
            k++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        longint total;
        int     beats;
        int     k;
        bit     seen;
        logic [KW-1:0] kp;

        tbl[0] = '{4, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0040};
        tbl[1] = '{3, 32'h0000_FFFF, 32'h0000_000F, 32'h0000_0024};
        tbl[2] = '{1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
        tbl[3] = '{1, 32'h0000_0001, 32'h0000_0001, 32'h0000_0001};
        tbl[4] = '{2, 32'h0000_FFFF, 32'h0000_8001, 32'h0000_0012};
        tbl[5] = '{5, 32'h0000_00FF, 32'h0000_00F0, 32'h0000_0024};
        tbl[6] = '{3, 32'hFFFF_FFFF, 32'h0001_0000, 32'h0000_0041};

        // Reset values, with the data stream active underneath.
        s_tvalid = 1'b1;
        s_tready = 1'b1;
        s_tlast  = 1'b1;
        s_tkeep  = '1;
        tick(3);
        check("rst_tvalid", 32'(sts_tvalid), 32'd0);
        check("rst_tlast", 32'(sts_tlast), 32'd0);
        check("rst_tdata", sts_tdata, 32'h0);
        check("rst_hold", 32'(hold), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("tkeep_const", 32'(sts_tkeep), 32'hF);
        s_tvalid = 1'b0;
        s_tready = 1'b0;
        s_tlast  = 1'b0;
        rst_n = 1'b1;
        tick(2);
        check("idle_tvalid", 32'(sts_tvalid), 32'd0);

        // Table vectors with sts_tready held high: latency, consecutive words, APP4 length.
        mode = 0;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(tbl[i].exp);
            send_pkt(tbl[i].beats, KW'(tbl[i].body), KW'(tbl[i].lastk), 0);
            check("pre_flag_idle", 32'(sts_tvalid), 32'd0);
            tick();
            check("flag_latency", sts_tdata, STS_FLAG);
            for (int w = 1; w < STS_WORDS; w++) begin
                tick();
                check("consecutive", 32'(sts_tvalid), 32'd1);
            end
            tick();
            check("post_idle", 32'(sts_tvalid), 32'd0);
            wait_drain("tbl_drain", 50);
        end

        // Three-beat packet with toggling sts_tready; stability checked by the monitor.
        mode = 1;
        exp_q.push_back(32'h24);
        send_pkt(3, ones(16), ones(4), 0);
        wait_drain("toggle_drain", 100);

        // Back-to-back packets: exactly one idle cycle between status packets.
        mode = 0;
        tick(3);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd3);
        send_beat(ones(1), 1'b1, 0, 1'b0);
        send_beat(ones(3), 1'b1, 0, 1'b0);
        for (int i = 0; i < 14; i++) begin
            check("b2b_valid", 32'(sts_tvalid), 32'((i % 7) != 6));
            tick();
        end
        wait_drain("b2b_drain", 50);

        // Fill the queue with sts_tready low; then push on a full queue in the cycle it pops.
        mode = 3;
        tick(2);
        for (int i = 0; i < 5; i++) begin
            exp_q.push_back(32'(16 + i));
            send_beat(ones(16 + i), 1'b1, 0, 1'b0);
            if (i == 3) check("hold_after_4", 32'(hold), 32'd0);
        end
        check("hold_after_5", 32'(hold), 32'd1);
        check("no_ovf_full", 32'(ovf), 32'd0);
        mode = 0;
        k = 0;
        while (sts_tvalid && k < 100) begin
            tick();
            k++;
        end
        check("idle_with_full_q", 32'(hold), 32'd1);
        exp_q.push_back(32'd7);
        send_beat(ones(7), 1'b1, 0, 1'b1);
        check("push_pop_full_ovf", 32'(ovf), 32'd0);
        check("push_pop_full_hold", 32'(hold), 32'd1);

        // Forced tlast beat while the queue is full: dropped and flagged.
        mode = 3;
        send_beat(ones(3), 1'b1, 0, 1'b1);
        check("ovf_set", 32'(ovf), 32'd1);
        mode = 0;
        wait_drain("ovf_drain", 200);
        check("hold_released", 32'(hold), 32'd0);
        exp_q.push_back(32'd9);
        send_pkt(1, ones(9), ones(9), 0);
        wait_drain("post_ovf_drain", 50);
        check("ovf_sticky", 32'(ovf), 32'd1);

        // Reset during APP2, then reset mid-packet: nothing emitted afterwards.
        exp_q.push_back(32'd5);
        send_pkt(1, ones(5), ones(5), 0);
        tick(4);
        check("in_app2", 32'(sts_tvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_app2_tvalid", 32'(sts_tvalid), 32'd0);
        check("rst_app2_tdata", sts_tdata, 32'h0);
        check("rst_ovf_clear", 32'(ovf), 32'd0);
        tick(2);
        exp_q.delete();
        rst_n = 1'b1;
        tick();
        send_beat(ones(16), 1'b0, 0, 1'b0);
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            seen |= sts_tvalid;
        end
        check("quiet_after_rst", 32'(seen), 32'd0);
        exp_q.push_back(32'd5);
        send_pkt(1, ones(5), ones(5), 0);
        wait_drain("after_rst_drain", 50);

        // Saturation: 32769 full beats of 256 bytes exceed 2^23-1.
        exp_q.push_back(32'h807F_FFFF);
        send_pkt(32769, '1, '1, 0);
        exp_q.push_back(32'd2);
        send_pkt(1, ones(2), ones(2), 0);
        wait_drain("sat_drain", 100);

        // Random packets, random gaps and sts_tready, producer obeying s2mm_hold.
        mode = 2;
        for (int p = 0; p < 40; p++) begin
            beats = $urandom_range(1, 4);
            total = 0;
            for (int b = 0; b < beats; b++) begin
                kp = rand_keep();
                total += $countones(kp);
                send_beat(kp, b == beats - 1, 30, 1'b0);
            end
            exp_q.push_back(model_word(total));
        end
        wait_drain("rand_drain", 3000);
        check("rand_no_ovf", 32'(ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
